// File: rtl/address_lookup_scheduler.sv
// address_lookup_scheduler
//   Shared MAC address table for a PORT_NUMBER-port switch. A round-robin arbiter accepts one
//   {source MAC, destination MAC} request at a time. The block looks up the destination, learns
//   the source against the granted port, and returns an egress port mask. The response pulse
//   comes exactly three cycles after the grant pulse.
//
//   Optional feature macro: ADDRESS_AGING_EN. When defined, entries that are not refreshed for
//   two AGE_PERIOD sweeps are invalidated. When undefined, entries leave the table only by flush
//   or by victim replacement.
//
// Ports
//   clock               rising-edge clock
//   reset               asynchronous reset, active low
//   request_valid       per-port pending request
//   request_source_mac  per-port source MAC (held until request_ready)
//   request_destin_mac  per-port destination MAC (held until request_ready)
//   request_ready       per-port one-cycle grant pulse
//   response_valid      per-port one-cycle response pulse
//   response_hit        destination found in table (qualified by response_valid)
//   response_port_mask  egress port mask (qualified by response_valid)
//   table_flush         level request to invalidate every entry (honoured in idle)
//   entry_count         number of valid entries
module address_lookup_scheduler #(
  parameter int unsigned PORT_NUMBER  = 4,
  parameter int unsigned ENTRY_NUMBER = 16
`ifdef ADDRESS_AGING_EN
  ,
  parameter int unsigned AGE_PERIOD   = 1000000
`endif
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [PORT_NUMBER-1:0]              request_valid,
  input  logic [PORT_NUMBER-1:0][47:0]        request_source_mac,
  input  logic [PORT_NUMBER-1:0][47:0]        request_destin_mac,
  output logic [PORT_NUMBER-1:0]              request_ready,
  output logic [PORT_NUMBER-1:0]              response_valid,
  output logic                                response_hit,
  output logic [PORT_NUMBER-1:0]              response_port_mask,
  input  logic                                table_flush,
  output logic [$clog2(ENTRY_NUMBER+1)-1:0]   entry_count
);

  localparam int unsigned PtrW   = (PORT_NUMBER > 1) ? $clog2(PORT_NUMBER) : 1;
  localparam int unsigned PtrW1  = PtrW + 1;
  localparam int unsigned IdxW   = (ENTRY_NUMBER > 1) ? $clog2(ENTRY_NUMBER) : 1;
  localparam int unsigned CountW = $clog2(ENTRY_NUMBER + 1);

  typedef enum logic [2:0] {StIdle, StGrant, StLookup, StLearn, StRespond} state_e;

  state_e                   state_q, state_d;
  logic [PtrW-1:0]          ptr_q, ptr_d;
  logic [PtrW-1:0]          grant_q, grant_d;
  logic [47:0]              src_q, src_d;
  logic [47:0]              dst_q, dst_d;
  logic                     hit_q, hit_d;
  logic [PORT_NUMBER-1:0]   mask_q, mask_d;
  logic [IdxW-1:0]          victim_q, victim_d;
  logic [CountW-1:0]        count_q, count_d;

  logic [ENTRY_NUMBER-1:0]  valid_q;
  logic [47:0]              mac_q  [ENTRY_NUMBER];
  logic [PtrW-1:0]          port_q [ENTRY_NUMBER];

  logic                     rr_found;
  logic [PtrW-1:0]          rr_idx;
  logic [PtrW:0]            cand;
  logic                     dst_hit, src_hit, free_found;
  logic [PtrW-1:0]          dst_port;
  logic [IdxW-1:0]          src_idx, free_idx, write_idx;
  logic                     do_flush, do_sweep, learn_en, write_new;
  logic [PORT_NUMBER-1:0]   self_mask, dst_onehot;
  logic [CountW-1:0]        survivors;
  logic                     sweep_pending;

`ifdef ADDRESS_AGING_EN
  localparam int unsigned AgeW = (AGE_PERIOD > 1) ? $clog2(AGE_PERIOD) : 1;

  logic [ENTRY_NUMBER-1:0]  active_q;
  logic [AgeW-1:0]          age_cnt_q;
  logic                     sweep_pending_q;

  assign sweep_pending = sweep_pending_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      age_cnt_q       <= '0;
      sweep_pending_q <= 1'b0;
    end else begin
      if (age_cnt_q == AgeW'(AGE_PERIOD - 1)) begin
        age_cnt_q       <= '0;
        sweep_pending_q <= 1'b1;
      end else begin
        age_cnt_q <= age_cnt_q + 1'b1;
        if (do_sweep) sweep_pending_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      active_q <= '0;
    end else if (do_flush || do_sweep) begin
      active_q <= '0;
    end else if (learn_en) begin
      active_q[write_idx] <= 1'b1;
    end
  end

  // Entries that survive a sweep: valid and touched since the previous sweep.
  always_comb begin
    survivors = '0;
    for (int e = 0; e < ENTRY_NUMBER; e++) begin
      survivors = survivors + CountW'(valid_q[e] & active_q[e]);
    end
  end
`else
  assign sweep_pending = 1'b0;
  assign survivors     = count_q;
`endif

  // Round-robin search starting at ptr_q.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int i = 0; i < PORT_NUMBER; i++) begin
      cand = {1'b0, ptr_q} + PtrW1'(i);
      if (cand >= PtrW1'(PORT_NUMBER)) cand = cand - PtrW1'(PORT_NUMBER);
      if (!rr_found && request_valid[cand[PtrW-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = cand[PtrW-1:0];
      end
    end
  end

  // Parallel table search: destination match, source match and lowest free slot.
  always_comb begin
    dst_hit    = 1'b0;
    dst_port   = '0;
    src_hit    = 1'b0;
    src_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int e = 0; e < ENTRY_NUMBER; e++) begin
      if (valid_q[e] && (mac_q[e] == dst_q)) begin
        dst_hit  = 1'b1;
        dst_port = port_q[e];
      end
      if (valid_q[e] && (mac_q[e] == src_q)) begin
        src_hit = 1'b1;
        src_idx = IdxW'(e);
      end
      if (!valid_q[e] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IdxW'(e);
      end
    end
  end

  // Table control strobes.
  always_comb begin
    do_flush  = (state_q == StIdle) && table_flush;
    do_sweep  = (state_q == StIdle) && !table_flush && sweep_pending;
    learn_en  = (state_q == StLearn) && !src_q[40];
    write_new = learn_en && !src_hit;
    if (src_hit)         write_idx = src_idx;
    else if (free_found) write_idx = free_idx;
    else                 write_idx = victim_q;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (!table_flush && !sweep_pending && rr_found) state_d = StGrant;
      StGrant:   state_d = StLookup;
      StLookup:  state_d = StLearn;
      StLearn:   state_d = StRespond;
      StRespond: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Datapath next state.
  always_comb begin
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    src_d      = src_q;
    dst_d      = dst_q;
    hit_d      = hit_q;
    mask_d     = mask_q;
    victim_d   = victim_q;
    count_d    = count_q;
    self_mask  = '0;
    dst_onehot = '0;
    self_mask[grant_q]  = 1'b1;
    dst_onehot[dst_port] = 1'b1;

    if ((state_q == StIdle) && (state_d == StGrant)) grant_d = rr_idx;

    if (state_q == StGrant) begin
      src_d = request_source_mac[grant_q];
      dst_d = request_destin_mac[grant_q];
      ptr_d = (grant_q == PtrW'(PORT_NUMBER - 1)) ? '0 : grant_q + 1'b1;
    end

    // Lookup sees the table as it was before this request's learn.
    if (state_q == StLookup) begin
      if (dst_q[40] || !dst_hit) begin
        hit_d  = 1'b0;
        mask_d = ~self_mask;
      end else if (dst_port == grant_q) begin
        hit_d  = 1'b1;
        mask_d = '0;
      end else begin
        hit_d  = 1'b1;
        mask_d = dst_onehot;
      end
    end

    if (do_flush) begin
      count_d  = '0;
      victim_d = '0;
    end else if (do_sweep) begin
      count_d = survivors;
    end else if (write_new) begin
      if (free_found) begin
        count_d = count_q + 1'b1;
      end else begin
        victim_d = (victim_q == IdxW'(ENTRY_NUMBER - 1)) ? '0 : victim_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      grant_q  <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      hit_q    <= 1'b0;
      mask_q   <= '0;
      victim_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      hit_q    <= hit_d;
      mask_q   <= mask_d;
      victim_q <= victim_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int e = 0; e < ENTRY_NUMBER; e++) begin
        mac_q[e]  <= '0;
        port_q[e] <= '0;
      end
    end else if (do_flush) begin
      valid_q <= '0;
`ifdef ADDRESS_AGING_EN
    end else if (do_sweep) begin
      valid_q <= valid_q & active_q;
`endif
    end else if (learn_en) begin
      // A station move rewrites the same MAC, so no duplicate can appear.
      valid_q[write_idx] <= 1'b1;
      mac_q[write_idx]   <= src_q;
      port_q[write_idx]  <= grant_q;
    end
  end

  // Outputs.
  always_comb begin
    request_ready      = '0;
    response_valid     = '0;
    response_hit       = 1'b0;
    response_port_mask = '0;
    if (state_q == StGrant) request_ready[grant_q] = 1'b1;
    if (state_q == StRespond) begin
      response_valid[grant_q] = 1'b1;
      response_hit            = hit_q;
      response_port_mask      = mask_q;
    end
  end

  assign entry_count = count_q;

endmodule

// File: tb/tb_address_lookup_scheduler.sv
module tb_address_lookup_scheduler;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [3:0]       request_valid;
  logic [3:0][47:0] request_source_mac;
  logic [3:0][47:0] request_destin_mac;
  logic [3:0]       request_ready;
  logic [3:0]       response_valid;
  logic             response_hit;
  logic [3:0]       response_port_mask;
  logic             table_flush;
  logic [4:0]       entry_count;

  int total = 0;
  int bad   = 0;

  localparam logic [47:0] Bcast = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] Mcast = 48'h0100_5E00_0001;

  always #5 clock = ~clock;

  address_lookup_scheduler dut (
    .clock              (clock),
    .reset              (reset),
    .request_valid      (request_valid),
    .request_source_mac (request_source_mac),
    .request_destin_mac (request_destin_mac),
    .request_ready      (request_ready),
    .response_valid     (response_valid),
    .response_hit       (response_hit),
    .response_port_mask (response_port_mask),
    .table_flush        (table_flush),
    .entry_count        (entry_count)
  );

  typedef struct {
    int         port;
    logic [47:0] src;
    logic [47:0] dst;
    logic        hit;
    logic [3:0]  mask;
    int          count;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [47:0] mac(input int n);
    return {40'h02_0000_0000, n[7:0]};
  endfunction

  function automatic logic [47:0] cap(input int n);
    return {40'h02_0000_0001, n[7:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one request from port p; returns the response and grant-to-response latency.
  task automatic do_req(input string name, input int p, input logic [47:0] src,
                        input logic [47:0] dst, input bit flush_mid, output logic hit,
                        output logic [3:0] mask, output int lat);
    int         waited;
    logic [3:0] oh;
    oh   = 4'b0001 << p;
    hit  = 1'b0;
    mask = 4'b0;
    lat  = -1;
    request_source_mac[p] = src;
    request_destin_mac[p] = dst;
    request_valid[p]      = 1'b1;
    waited = 0;
    while (1) begin
      @(negedge clock);
      waited++;
      if (request_ready[p] === 1'b1 || waited >= 50) break;
    end
    request_valid[p] = 1'b0;
    check({name, " ready"}, {60'd0, request_ready}, {60'd0, oh});
    if (waited >= 50) return;
    lat = 0;
    while (1) begin
      @(negedge clock);
      lat++;
      if (flush_mid && lat == 1) table_flush = 1'b1;
      if (response_valid !== 4'b0 || lat >= 20) break;
    end
    check({name, " rsp_valid"}, {60'd0, response_valid}, {60'd0, oh});
    hit  = response_hit;
    mask = response_port_mask;
  endtask

  task automatic run_vec(input string name, input int p, input logic [47:0] src,
                         input logic [47:0] dst, input logic exp_hit, input logic [3:0] exp_mask,
                         input int exp_count);
    logic       hit;
    logic [3:0] mask;
    int         lat;
    do_req(name, p, src, dst, 1'b0, hit, mask, lat);
    check({name, " latency"}, lat, 3);
    check({name, " hit"}, {63'd0, hit}, {63'd0, exp_hit});
    check({name, " mask"}, {60'd0, mask}, {60'd0, exp_mask});
    check({name, " count"}, {59'd0, entry_count}, exp_count);
  endtask

  initial begin
    logic       hit;
    logic [3:0] mask;
    logic [3:0] exp_m;
    int         lat, waited, exp_next, last_g, nrsp, cyc;
    bit         outstanding;

    vecs[0] = '{1, mac(1), mac(2), 1'b0, 4'b1101, 1};
    vecs[1] = '{2, mac(2), mac(1), 1'b1, 4'b0010, 2};
    vecs[2] = '{3, mac(3), Bcast,  1'b0, 4'b0111, 3};
    vecs[3] = '{0, Mcast,  mac(3), 1'b1, 4'b1000, 3};
    vecs[4] = '{1, mac(2), mac(1), 1'b1, 4'b0000, 3};  // station move; dst on own port
    vecs[5] = '{3, mac(4), mac(2), 1'b1, 4'b0010, 4};
    vecs[6] = '{0, mac(5), Mcast,  1'b0, 4'b1110, 5};

    request_valid      = '0;
    request_source_mac = '0;
    request_destin_mac = '0;
    table_flush        = 1'b0;

    // Reset state.
    repeat (2) @(negedge clock);
    check("rst count", {59'd0, entry_count}, 0);
    check("rst ready", {60'd0, request_ready}, 0);
    check("rst rsp_valid", {60'd0, response_valid}, 0);
    check("rst hit", {63'd0, response_hit}, 0);
    check("rst mask", {60'd0, response_port_mask}, 0);
    reset = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 7; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i].port, vecs[i].src, vecs[i].dst, vecs[i].hit,
              vecs[i].mask, vecs[i].count);
    end

    // Reset during lookup drops the pending response and empties the table.
    request_source_mac[1] = mac(7);
    request_destin_mac[1] = mac(8);
    request_valid[1]      = 1'b1;
    waited = 0;
    while (1) begin
      @(negedge clock);
      waited++;
      if (request_ready[1] === 1'b1 || waited >= 50) break;
    end
    request_valid[1] = 1'b0;
    check("midrst ready", {60'd0, request_ready}, 4'b0010);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("midrst count", {59'd0, entry_count}, 0);
    @(negedge clock);
    reset = 1'b1;
    nrsp = 0;
    repeat (6) begin
      @(negedge clock);
      if (response_valid !== 4'b0) nrsp++;
    end
    check("midrst no rsp", nrsp, 0);

    // All four ports at once from pointer 0.
    for (int p = 0; p < 4; p++) begin
      request_source_mac[p] = mac(16 + p);
      request_destin_mac[p] = mac(32);
    end
    request_valid = 4'b1111;
    exp_next = 0;
    last_g = 0;
    outstanding = 1'b0;
    nrsp = 0;
    cyc = 0;
    while (nrsp < 4 && cyc < 100) begin
      @(negedge clock);
      cyc++;
      if (request_ready !== 4'b0) begin
        check($sformatf("rr grant%0d", exp_next), {60'd0, request_ready}, 64'd1 << exp_next);
        check($sformatf("rr overlap%0d", exp_next), {63'd0, outstanding}, 0);
        request_valid = request_valid & ~request_ready;
        outstanding = 1'b1;
        last_g = exp_next;
        exp_next++;
      end
      if (response_valid !== 4'b0) begin
        exp_m = ~(4'b0001 << last_g);
        check($sformatf("rr rsp%0d", last_g), {60'd0, response_valid}, 64'd1 << last_g);
        check($sformatf("rr mask%0d", last_g), {60'd0, response_port_mask}, {60'd0, exp_m});
        outstanding = 1'b0;
        nrsp++;
      end
    end
    check("rr responses", nrsp, 4);
    request_valid = '0;
    check("rr count", {59'd0, entry_count}, 4);

    // Flush raised during lookup: response completes, flush lands after idle.
    do_req("flush", 2, mac(6), mac(10), 1'b1, hit, mask, lat);
    check("flush latency", lat, 3);
    check("flush hit", {63'd0, hit}, 0);
    check("flush mask", {60'd0, mask}, 4'b1011);
    check("flush count rsp", {59'd0, entry_count}, 5);
    @(negedge clock);
    check("flush count idle", {59'd0, entry_count}, 5);
    @(negedge clock);
    check("flush count after", {59'd0, entry_count}, 0);
    table_flush = 1'b0;

    // Fill past capacity; victim replacement starts at entry 0.
    for (int i = 1; i <= 17; i++) begin
      run_vec($sformatf("cap%0d", i), 0, cap(i), Bcast, 1'b0, 4'b1110, (i > 16) ? 16 : i);
    end
    run_vec("cap look1", 1, Mcast, cap(1), 1'b0, 4'b1101, 16);
    run_vec("cap look2", 1, Mcast, cap(2), 1'b1, 4'b0001, 16);
    run_vec("cap look17", 1, Mcast, cap(17), 1'b1, 4'b0001, 16);
    run_vec("cap learn18", 0, cap(18), Bcast, 1'b0, 4'b1110, 16);
    run_vec("cap look2b", 1, Mcast, cap(2), 1'b0, 4'b1101, 16);
    run_vec("cap look3", 1, Mcast, cap(3), 1'b1, 4'b0001, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
